fetch_stage_ctrl: RTL and testbench
===================================

Name: fetch_stage_ctrl

Overview:
Front-end responder to the hazard unit's stall outputs. Owns the PC register and the IF/ID pipeline register, and obeys PC_write / IF_ID_write stalls and ID-stage branch redirects. Drives a variable-latency instruction memory through a req/ready handshake. Sits between instruction memory and the ID stage, and exposes stall and flush counters for performance checking.

Parameters:
PC_WIDTH, 32, width of PC and instruction-memory address.
RESET_PC, 32'h0000_0000, PC value after reset.
CNT_WIDTH, 16, width of the saturating stall and flush counters.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
PC_write  in  1  from hazard unit; 0 = freeze PC
IF_ID_write  in  1  from hazard unit; 0 = hold IF/ID
branch_taken  in  1  ID-stage branch resolved taken
branch_target  in  PC_WIDTH  redirect address, valid with branch_taken
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address (= PC)
imem_ready  in  1  memory completes the request this cycle
imem_rdata  in  32  instruction, valid when imem_req && imem_ready
IF_ID_instr  out  32  instruction to ID stage
IF_ID_pc4  out  PC_WIDTH  PC+4 of that instruction
IF_ID_valid  out  1  IF/ID holds a real instruction
stall_cnt  out  CNT_WIDTH  cycles with stall asserted
flush_cnt  out  CNT_WIDTH  honored branch redirects

Behaviour:
- stall = ~PC_write | ~IF_ID_write. The hazard unit drives both low together; any mismatch is treated as a stall.
- Reset (async, rst_n=0):
  - pc = RESET_PC; state = FETCH.
  - IF_ID_instr = 0 (NOP), IF_ID_pc4 = 0, IF_ID_valid = 0.
  - Hold buffer empty; stall_cnt = 0; flush_cnt = 0.
  - Reset mid-request abandons the request. Memory must tolerate imem_req dropping.
- imem_addr = pc at all times.
- Handshake:
  - imem_req = 1 in FETCH and DISCARD, 0 in HOLD.
  - imem_addr is stable while imem_req=1 and imem_ready=0.
  - A fetch completes in the cycle with imem_req && imem_ready, giving 0-wait-state latency 1 cycle per instruction.
- State FETCH:
  - Complete, no stall, no branch_taken: IF_ID_instr <= imem_rdata; IF_ID_pc4 <= pc+4; IF_ID_valid <= 1; pc <= pc+4.
  - Complete with stall: IF/ID and pc unchanged; imem_rdata -> hold buffer; state -> HOLD.
  - Not complete, no stall: IF_ID_instr <= 0; IF_ID_valid <= 0 (bubble); pc unchanged.
  - Not complete, stall: IF/ID unchanged.
- State HOLD:
  - stall: everything holds.
  - No stall, no branch_taken: hold buffer -> IF/ID (valid 1, pc4 = pc+4); pc <= pc+4; state -> FETCH.
- branch_taken (honored only when stall=0; ignored while stalled), highest priority over every state:
  - pc <= branch_target; IF_ID_instr <= 0; IF_ID_valid <= 0; hold buffer discarded; flush_cnt += 1.
  - Checked in FETCH: if the current request completes this cycle, its data is dropped; state -> FETCH.
  - Checked in FETCH: if the request is outstanding and not complete, the target goes to redirect_pc and state -> DISCARD; pc is not updated yet, so imem_addr stays stable.
  - Checked in HOLD: state -> FETCH.
- State DISCARD:
  - imem_req stays 1 at the old pc.
  - On imem_ready: data dropped; pc <= redirect_pc; state -> FETCH.
  - IF/ID outputs bubbles while not stalled.
  - A second branch_taken in DISCARD overwrites redirect_pc and counts again.
- pc+4 wraps modulo 2^PC_WIDTH; no trap.
- Counters:
  - stall_cnt increments each cycle stall=1 while rst_n=1.
  - flush_cnt increments on each honored branch_taken.
  - Both saturate at all-ones.
- IF_ID_pc4 of a bubble is don't-care but is driven deterministically (held).

Test Plan:
1. Reset release, imem_ready tied 1, instr memory returns addr-indexed words -> IF_ID_valid first high on cycle 1 with IF_ID_pc4=4; pc sequence 0,4,8,12 on consecutive cycles.
2. Load-use stall: PC_write=IF_ID_write=0 for 1 cycle while fetching pc=8 -> pc stays 8, IF/ID keeps the pc=4 instruction, word@8 is held. Next cycle it enters IF/ID with pc4=12 and pc=12; stall_cnt=1.
3. imem_ready low 3 cycles at pc=16, no stall -> imem_addr=16 stable for 4 cycles; 3 bubbles (IF_ID_valid=0) appear, then word@16 valid.
4. branch_taken with target 0x40 while the request at 0x20 has imem_ready=0 for 2 more cycles -> imem_addr stays 0x20 until ready; returned data is discarded (IF_ID_valid=0); next request at 0x40; flush_cnt=1.
5. branch_taken asserted while PC_write=0 -> ignored; pc unchanged; flush_cnt unchanged.
6. Force stall for 2^CNT_WIDTH+5 cycles; rst_n pulsed low mid-DISCARD -> stall_cnt saturates at all-ones; after reset all outputs return to reset values immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns PC and IF/ID, obeys hazard stalls,
// handles branch redirects over a variable-latency imem handshake.
module fetch_stage_ctrl #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 PC_write,
  input  logic                 IF_ID_write,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          IF_ID_instr,
  output logic [PC_WIDTH-1:0]  IF_ID_pc4,
  output logic                 IF_ID_valid,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next4;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [31:0]         hold_buf;
  logic                stall;
  logic                done;
  logic                br;

  assign stall     = ~PC_write | ~IF_ID_write;
  assign imem_req  = (state != HOLD);
  assign imem_addr = pc;
  assign done      = imem_req & imem_ready;
  assign br        = branch_taken & ~stall;
  assign pc_next4  = pc + PC_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= '0;
      hold_buf    <= '0;
      IF_ID_instr <= '0;
      IF_ID_pc4   <= '0;
      IF_ID_valid <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (br && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);

      if (br) begin
        IF_ID_instr <= '0;
        IF_ID_valid <= 1'b0;
        unique case (state)
          FETCH: begin
            // Outstanding request: keep addr stable, redirect later
            if (done) begin
              pc <= branch_target;
            end else begin
              redirect_pc <= branch_target;
              state       <= DISCARD;
            end
          end
          DISCARD: begin
            if (done) begin
              pc    <= branch_target;
              state <= FETCH;
            end else begin
              redirect_pc <= branch_target;
            end
          end
          HOLD: begin
            pc    <= branch_target;
            state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end else begin
        unique case (state)
          FETCH: begin
            unique case (1'b1)
              done & ~stall: begin
                IF_ID_instr <= imem_rdata;
                IF_ID_pc4   <= pc_next4;
                IF_ID_valid <= 1'b1;
                pc          <= pc_next4;
              end
              done & stall: begin
                hold_buf <= imem_rdata;
                state    <= HOLD;
              end
              ~done & ~stall: begin
                IF_ID_instr <= '0;
                IF_ID_valid <= 1'b0;
              end
              default: ;
            endcase
          end
          HOLD: begin
            if (!stall) begin
              IF_ID_instr <= hold_buf;
              IF_ID_pc4   <= pc_next4;
              IF_ID_valid <= 1'b1;
              pc          <= pc_next4;
              state       <= FETCH;
            end
          end
          DISCARD: begin
            if (done) begin
              pc    <= redirect_pc;
              state <= FETCH;
            end
            if (!stall) begin
              IF_ID_instr <= '0;
              IF_ID_valid <= 1'b0;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: directed vectors, queued
// expectations popped whenever ID accepts a valid IF/ID entry.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_write;
  logic        IF_ID_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  fetch_stage_ctrl #(
    .PC_WIDTH(32),
    .RESET_PC(32'h0),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .PC_write(PC_write),
    .IF_ID_write(IF_ID_write),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .IF_ID_instr(IF_ID_instr),
    .IF_ID_pc4(IF_ID_pc4),
    .IF_ID_valid(IF_ID_valid),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.instr = word_at(a);
    e.pc4   = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && IF_ID_valid && PC_write && IF_ID_write) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: got instr %h pc4 %h expected none",
                 IF_ID_instr, IF_ID_pc4);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (IF_ID_instr !== e.instr || IF_ID_pc4 !== e.pc4) begin
          miscompares++;
          $display("FAIL sb_ifid: got %h/%h expected %h/%h",
                   IF_ID_instr, IF_ID_pc4, e.instr, e.pc4);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ready    = 1'b1;
    tick();
    tick();
    chk("rst_addr", 64'(imem_addr), 64'h0);
    chk("rst_valid", 64'(IF_ID_valid), 64'h0);
    chk("rst_instr", 64'(IF_ID_instr), 64'h0);
    chk("rst_pc4", 64'(IF_ID_pc4), 64'h0);
    chk("rst_cnts", {32'(stall_cnt), 32'(flush_cnt)}, 64'h0);
    chk("rst_req", 64'(imem_req), 64'h1);

    // 1: streaming fetch
    rst_n = 1'b1;
    push(32'h0);
    tick();
    chk("t1_valid", 64'(IF_ID_valid), 64'h1);
    chk("t1_pc4", 64'(IF_ID_pc4), 64'h4);
    chk("t1_addr4", 64'(imem_addr), 64'h4);
    push(32'h4);
    tick();
    chk("t1_addr8", 64'(imem_addr), 64'h8);

    // 2: one-cycle load-use stall at pc=8
    PC_write    = 1'b0;
    IF_ID_write = 1'b0;
    tick();
    chk("t2_addr", 64'(imem_addr), 64'h8);
    chk("t2_hold_pc4", 64'(IF_ID_pc4), 64'h8);
    chk("t2_req", 64'(imem_req), 64'h0);
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    push(32'h8);
    tick();
    chk("t2_pc4", 64'(IF_ID_pc4), 64'hC);
    chk("t2_addr12", 64'(imem_addr), 64'hC);
    chk("t2_stall_cnt", 64'(stall_cnt), 64'h1);

    // 3: three wait states at pc=16
    push(32'hC);
    tick();
    imem_ready = 1'b0;
    chk("t3_addr0", 64'(imem_addr), 64'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_addr", 64'(imem_addr), 64'h10);
      chk("t3_bubble", 64'(IF_ID_valid), 64'h0);
    end
    imem_ready = 1'b1;
    push(32'h10);
    tick();
    chk("t3_valid", 64'(IF_ID_valid), 64'h1);
    chk("t3_addr20", 64'(imem_addr), 64'h14);

    // 4: branch to 0x40 during an outstanding request at 0x20
    push(32'h14);
    tick();
    push(32'h18);
    tick();
    push(32'h1C);
    tick();
    chk("t4_addr20", 64'(imem_addr), 64'h20);
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    chk("t4_addr_a", 64'(imem_addr), 64'h20);
    chk("t4_req", 64'(imem_req), 64'h1);
    chk("t4_bubble_a", 64'(IF_ID_valid), 64'h0);
    chk("t4_flush", 64'(flush_cnt), 64'h1);
    tick();
    chk("t4_addr_b", 64'(imem_addr), 64'h20);
    imem_ready = 1'b1;
    tick();
    chk("t4_addr40", 64'(imem_addr), 64'h40);
    chk("t4_drop", 64'(IF_ID_valid), 64'h0);
    push(32'h40);
    tick();
    chk("t4_valid40", 64'(IF_ID_valid), 64'h1);
    chk("t4_addr44", 64'(imem_addr), 64'h44);

    // 5: branch while PC_write=0 is ignored
    PC_write      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    chk("t5_addr", 64'(imem_addr), 64'h44);
    chk("t5_flush", 64'(flush_cnt), 64'h1);
    chk("t5_stall_cnt", 64'(stall_cnt), 64'h2);
    PC_write     = 1'b1;
    branch_taken = 1'b0;
    push(32'h44);
    tick();
    chk("t5_addr48", 64'(imem_addr), 64'h48);

    // 6: enter DISCARD, saturate stall_cnt, reset mid-DISCARD
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    chk("t6_flush", 64'(flush_cnt), 64'h2);
    PC_write    = 1'b0;
    IF_ID_write = 1'b0;
    for (int i = 0; i < 65536 + 5; i++) tick();
    chk("t6_sat", 64'(stall_cnt), 64'hFFFF);
    chk("t6_addr", 64'(imem_addr), 64'h48);
    chk("t6_req", 64'(imem_req), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_addr", 64'(imem_addr), 64'h0);
    chk("t6_rst_valid", 64'(IF_ID_valid), 64'h0);
    chk("t6_rst_ifid", {IF_ID_instr, IF_ID_pc4}, 64'h0);
    chk("t6_rst_cnts", {32'(stall_cnt), 32'(flush_cnt)}, 64'h0);
    chk("t6_rst_req", 64'(imem_req), 64'h1);
    tick();
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    imem_ready  = 1'b1;
    rst_n       = 1'b1;
    push(32'h0);
    tick();
    chk("t6_restart_valid", 64'(IF_ID_valid), 64'h1);
    chk("t6_restart_pc4", 64'(IF_ID_pc4), 64'h4);
    chk("t6_restart_addr", 64'(imem_addr), 64'h4);
    push(32'h4);
    tick();
    @(negedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
